exc_commit_ctrl: RTL and testbench
==================================

Name: exc_commit_ctrl

Overview:
- Sits between the writeback stage and the CSR file. It decides which instructions commit and which raise exceptions, interrupts or ERTN.
- For each trap event it sequences the work:
  - drives one-cycle exception/ERTN strobes into the CSR file;
  - holds a pipeline-wide flush while in-flight state drains;
  - issues a redirect to the fetch stage with a valid/ready handshake.
- Priority between simultaneous sources is resolved here. The CSR file then only sees one clean event per trap.

Parameters:
- DRAIN_CYCLES, 2: cycles flush_all stays asserted after the CSR strobe, before the redirect is offered. Legal range 0..15.
- INT_ECODE, 6'h00: ecode reported for interrupts.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- ws_valid  in  1  WB stage holds a valid instruction
- ws_pc  in  32  PC of WB instruction
- ws_ex  in  1  WB instruction carries a synchronous exception
- ws_ecode  in  6  exception code from pipeline
- ws_esubcode  in  9  exception subcode
- ws_vaddr  in  32  faulting data address
- ws_ertn  in  1  WB instruction is ERTN
- has_int  in  1  pending enabled interrupt (from CSR file)
- ex_entry  in  32  exception entry address (from CSR file)
- era_value  in  32  current ERA (from CSR file)
- redirect_ready  in  1  fetch stage accepts redirect
- ws_ready  out  1  WB may present/advance; high only in IDLE
- ws_commit  out  1  WB instruction retires normally (regfile/CSR write enable gate)
- wb_ex  out  1  one-cycle exception strobe to CSR file
- wb_ecode  out  6  latched ecode
- wb_esubcode  out  9  latched esubcode
- wb_pc  out  32  latched PC for ERA/BADV
- wb_vaddr  out  32  latched bad vaddr
- ertn_flush  out  1  one-cycle ERTN strobe to CSR file
- flush_all  out  1  flush every pipeline stage
- redirect_valid  out  1  redirect offered to fetch
- redirect_pc  out  32  redirect target
- trap_count  out  32  number of completed traps (exceptions + interrupts + ERTN)

Behaviour:
- Reset (asynchronous, resetn=0): state=IDLE, drain counter=0, trap_count=0. All outputs 0, including ws_ready and the latched code/pc/vaddr/target regs.
- Event decode in IDLE, with ev = ws_valid & (ws_ex | has_int | ws_ertn). Priority:
  - ws_ex: ecode=ws_ecode, esubcode=ws_esubcode;
  - else has_int: ecode=INT_ECODE, esubcode=0;
  - else ws_ertn.
- Interrupts are taken only on a valid WB instruction, with pc=ws_pc. That instruction does not commit.
- ws_commit = ws_valid & (state==IDLE) & ~ev. It is combinational; no instruction retires outside IDLE.
- FSM states are IDLE, SIGNAL, DRAIN, REDIRECT.
- IDLE:
  - ws_ready=1.
  - On ev: latch ecode/esubcode/ws_pc/ws_vaddr and the kind (EX or ERTN). Next state is SIGNAL.
- SIGNAL (exactly 1 cycle):
  - EX kind: wb_ex=1. ERTN kind: ertn_flush=1. Never both.
  - flush_all=1, ws_ready=0.
  - Next state is DRAIN with counter=DRAIN_CYCLES, or REDIRECT directly if DRAIN_CYCLES==0.
- DRAIN:
  - flush_all=1, counter decrements each cycle.
  - Leaves for REDIRECT in the cycle the counter equals 1.
- Redirect target capture: the target is latched on entry to REDIRECT, after the CSR update has landed.
  - EX kind: ex_entry.
  - ERTN kind: era_value.
- REDIRECT:
  - redirect_valid=1 and flush_all=1. redirect_pc stays stable until accepted.
  - When redirect_valid & redirect_ready: trap_count+=1 (wraps 32'hFFFFFFFF→0), next state is IDLE.
  - Redirect is accepted at the earliest in the same cycle it is first offered.
- Strobe latency: wb_ex/ertn_flush rise exactly 1 cycle after the IDLE cycle that saw ev.
- Minimum trap length is IDLE→IDLE of 2+DRAIN_CYCLES+1 cycles when redirect_ready is held high.
- Stability: wb_ecode/wb_esubcode/wb_pc/wb_vaddr hold their latched values until the next event is latched.
- Inputs outside IDLE: ws_* and has_int are ignored in non-IDLE states. An interrupt pending on return to IDLE is taken on the next valid WB instruction.
- Same-cycle sources: ws_ertn together with ws_ex is an EX trap. ws_ertn together with has_int is an interrupt; the ERTN does not commit and is re-executed after return.
- Mid-operation reset: a resetn assertion in any state returns to IDLE immediately, aborts any redirect and clears the strobes.

Test Plan:
- Exception trap:
  - Stimulus: ws_valid=1, ws_ex=1, ecode=6'h0b, pc=32'h1c000100, DRAIN_CYCLES=2, redirect_ready=1, ex_entry=32'h1c008000.
  - Required: wb_ex high cycle 1, flush_all cycles 1-4, redirect_valid with pc 32'h1c008000 at cycle 4, ws_commit=0, trap_count=1.
- ERTN:
  - Stimulus: ws_ertn=1, era_value=32'h1c000204.
  - Required: ertn_flush one cycle, wb_ex stays 0, redirect_pc=32'h1c000204.
- Priority:
  - Stimulus: ws_ex=1 (ecode 6'h09), has_int=1 and ws_ertn=1 in the same cycle.
  - Required: wb_ex with ecode 6'h09.
  - Repeat with ws_ex=0: ecode 6'h00, esubcode 0, ertn_flush never asserted.
- Redirect backpressure:
  - Stimulus: redirect_ready=0 for 5 cycles, while ws_valid toggles and ws_ex=1 is pulsed.
  - Required: redirect_valid and redirect_pc stable; no new strobe; trap_count increments only once, on acceptance.
- Normal flow:
  - Stimulus: ws_valid=1 with no ex/int/ertn for 10 cycles.
  - Required: ws_commit=1 every cycle, flush_all=0.
  - Set DRAIN_CYCLES=0: redirect offered 2 cycles after the event cycle.
- Reset:
  - Stimulus: resetn=0 asserted during DRAIN.
  - Required: all outputs 0 asynchronously, trap_count=0, ws_ready=1 after resetn release.

Source files
------------

// File: rtl/exc_commit_ctrl.sv
// Writeback commit / trap sequencer: arbitrates exception, interrupt and ERTN
// sources, strobes the CSR file once per trap, drains the pipeline, then redirects fetch.
//
// state    | meaning
// IDLE     | WB instructions commit; trap sources are sampled
// SIGNAL   | one-cycle wb_ex or ertn_flush strobe to the CSR file
// DRAIN    | flush held while in-flight state settles
// REDIRECT | redirect offered to fetch until accepted
module exc_commit_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter logic [5:0]  INT_ECODE    = 6'h00
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ws_valid,
  input  logic [31:0] ws_pc,
  input  logic        ws_ex,
  input  logic [5:0]  ws_ecode,
  input  logic [8:0]  ws_esubcode,
  input  logic [31:0] ws_vaddr,
  input  logic        ws_ertn,
  input  logic        has_int,
  input  logic [31:0] ex_entry,
  input  logic [31:0] era_value,
  input  logic        redirect_ready,
  output logic        ws_ready,
  output logic        ws_commit,
  output logic        wb_ex,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_vaddr,
  output logic        ertn_flush,
  output logic        flush_all,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] trap_count
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SIGNAL   = 2'd1,
    S_DRAIN    = 2'd2,
    S_REDIRECT = 2'd3
  } state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

  state_t      state, state_nxt;
  logic [3:0]  drain_cnt, drain_cnt_nxt;
  logic        kind_ertn;
  logic        ev;
  logic        in_idle;
  logic        take_event;
  logic        enter_redirect;
  logic        accept;

  assign ev             = ws_valid & (ws_ex | has_int | ws_ertn);
  assign in_idle        = (state == S_IDLE);
  assign take_event     = in_idle & ev;
  assign enter_redirect = (state != S_REDIRECT) & (state_nxt == S_REDIRECT);
  assign accept         = (state == S_REDIRECT) & redirect_ready;

  // Gated by resetn so nothing looks ready or retires while reset is held.
  assign ws_ready  = resetn & in_idle;
  assign ws_commit = resetn & in_idle & ws_valid & ~ev;

  always_comb begin
    state_nxt      = state;
    drain_cnt_nxt  = drain_cnt;
    wb_ex          = 1'b0;
    ertn_flush     = 1'b0;
    flush_all      = 1'b0;
    redirect_valid = 1'b0;
    case (state)
      S_IDLE: begin
        if (ev) state_nxt = S_SIGNAL;
      end
      S_SIGNAL: begin
        wb_ex      = ~kind_ertn;
        ertn_flush = kind_ertn;
        flush_all  = 1'b1;
        if (DRAIN_LOAD == 4'd0) begin
          state_nxt = S_REDIRECT;
        end else begin
          state_nxt     = S_DRAIN;
          drain_cnt_nxt = DRAIN_LOAD;
        end
      end
      S_DRAIN: begin
        flush_all     = 1'b1;
        drain_cnt_nxt = drain_cnt - 4'd1;
        // <= 1 rather than == 1 so a corrupted zero count cannot stall here.
        if (drain_cnt <= 4'd1) state_nxt = S_REDIRECT;
      end
      S_REDIRECT: begin
        flush_all      = 1'b1;
        redirect_valid = 1'b1;
        if (redirect_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      drain_cnt <= 4'd0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  // Event capture: exception beats interrupt beats ERTN.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      kind_ertn   <= 1'b0;
      wb_ecode    <= 6'd0;
      wb_esubcode <= 9'd0;
      wb_pc       <= 32'd0;
      wb_vaddr    <= 32'd0;
    end else if (take_event) begin
      wb_pc    <= ws_pc;
      wb_vaddr <= ws_vaddr;
      if (ws_ex) begin
        kind_ertn   <= 1'b0;
        wb_ecode    <= ws_ecode;
        wb_esubcode <= ws_esubcode;
      end else if (has_int) begin
        kind_ertn   <= 1'b0;
        wb_ecode    <= INT_ECODE;
        wb_esubcode <= 9'd0;
      end else begin
        kind_ertn   <= 1'b1;
        wb_ecode    <= 6'd0;
        wb_esubcode <= 9'd0;
      end
    end
  end

  // Target is sampled only once the CSR update from SIGNAL has landed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      redirect_pc <= 32'd0;
    end else if (enter_redirect) begin
      redirect_pc <= kind_ertn ? era_value : ex_entry;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      trap_count <= 32'd0;
    end else if (accept) begin
      trap_count <= trap_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Bench for exc_commit_ctrl: directed traps feed expectation queues that a
// negedge monitor drains as strobes and redirects appear.
module tb_exc_commit_ctrl;

  typedef struct {
    int          cyc;
    bit          is_ex;
    bit          chk_code;
    logic [5:0]  ecode;
    logic [8:0]  sub;
    logic [31:0] pc;
    logic [31:0] vaddr;
  } strobe_t;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
  } redir_t;

  localparam logic [31:0] ENTRY = 32'h1c008000;
  localparam logic [31:0] ERA   = 32'h1c000204;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ws_valid, ws_ex, ws_ertn, has_int, redirect_ready;
  logic [31:0] ws_pc, ws_vaddr, ex_entry, era_value;
  logic [5:0]  ws_ecode;
  logic [8:0]  ws_esubcode;
  logic        z_valid, z_ex, z_ertn;

  logic        ws_ready, ws_commit, wb_ex, ertn_flush, flush_all, redirect_valid;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc, wb_vaddr, redirect_pc, trap_count;

  logic        z_ws_ready, z_ws_commit, z_wb_ex, z_ertn_flush, z_flush_all, z_redirect_valid;
  logic [5:0]  z_wb_ecode;
  logic [8:0]  z_wb_esubcode;
  logic [31:0] z_wb_pc, z_wb_vaddr, z_redirect_pc, z_trap_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  strobe_t sq[$];
  redir_t  rq[$];

  exc_commit_ctrl #(.DRAIN_CYCLES(2), .INT_ECODE(6'h00)) dut (
    .clk(clk), .resetn(resetn), .ws_valid(ws_valid), .ws_pc(ws_pc), .ws_ex(ws_ex),
    .ws_ecode(ws_ecode), .ws_esubcode(ws_esubcode), .ws_vaddr(ws_vaddr), .ws_ertn(ws_ertn),
    .has_int(has_int), .ex_entry(ex_entry), .era_value(era_value),
    .redirect_ready(redirect_ready), .ws_ready(ws_ready), .ws_commit(ws_commit),
    .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc),
    .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush), .flush_all(flush_all),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .trap_count(trap_count)
  );

  exc_commit_ctrl #(.DRAIN_CYCLES(0), .INT_ECODE(6'h00)) dut_z (
    .clk(clk), .resetn(resetn), .ws_valid(z_valid), .ws_pc(ws_pc), .ws_ex(z_ex),
    .ws_ecode(ws_ecode), .ws_esubcode(ws_esubcode), .ws_vaddr(ws_vaddr), .ws_ertn(z_ertn),
    .has_int(1'b0), .ex_entry(ex_entry), .era_value(era_value),
    .redirect_ready(redirect_ready), .ws_ready(z_ws_ready), .ws_commit(z_ws_commit),
    .wb_ex(z_wb_ex), .wb_ecode(z_wb_ecode), .wb_esubcode(z_wb_esubcode), .wb_pc(z_wb_pc),
    .wb_vaddr(z_wb_vaddr), .ertn_flush(z_ertn_flush), .flush_all(z_flush_all),
    .redirect_valid(z_redirect_valid), .redirect_pc(z_redirect_pc), .trap_count(z_trap_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ws();
    ws_valid = 1'b0; ws_ex = 1'b0; ws_ertn = 1'b0; has_int = 1'b0;
    ws_ecode = 6'h00; ws_esubcode = 9'h000; ws_vaddr = 32'h0;
  endtask

  // Presents one trap-raising WB instruction for one cycle and queues what must follow.
  task automatic trap(input bit ex, input bit ertn, input bit intr,
                      input logic [5:0] ecode, input logic [8:0] sub,
                      input logic [31:0] pc, input logic [31:0] vaddr,
                      input bit exp_is_ex, input logic [5:0] exp_ecode,
                      input logic [8:0] exp_sub, input logic [31:0] exp_target);
    strobe_t s;
    redir_t  r;
    ws_valid = 1'b1; ws_ex = ex; ws_ertn = ertn; has_int = intr;
    ws_ecode = ecode; ws_esubcode = sub; ws_pc = pc; ws_vaddr = vaddr;
    s.cyc = cyc + 1; s.is_ex = exp_is_ex; s.chk_code = exp_is_ex;
    s.ecode = exp_ecode; s.sub = exp_sub; s.pc = pc; s.vaddr = vaddr;
    sq.push_back(s);
    r.cyc = cyc + 4; r.pc = exp_target;
    rq.push_back(r);
    #1;
    check("trap_no_commit", ws_commit, 0);
    tick();
    clear_ws();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!ws_ready && n < 40) begin
      tick();
      n++;
    end
    check(name, ws_ready, 1);
  endtask

  // Monitor: pops expectations when the DUT strobes or hands off a redirect.
  strobe_t     ms;
  redir_t      mr;
  int          exp_count   = 0;
  bit          inc_pending = 1'b0;
  bit          prev_rv     = 1'b0;
  logic [31:0] prev_rpc    = 32'h0;
  int          first_offer = 0;

  always @(negedge clk) begin
    if (!resetn) begin
      exp_count   = 0;
      inc_pending = 1'b0;
      prev_rv     = 1'b0;
    end else if (mon_en) begin
      if (inc_pending) exp_count++;
      inc_pending = 1'b0;
      check("trap_count", trap_count, exp_count);
      if (wb_ex || ertn_flush) begin
        if (sq.size() == 0) begin
          check("unexpected_strobe", {wb_ex, ertn_flush}, 0);
        end else begin
          ms = sq.pop_front();
          check("strobe_cycle", cyc, ms.cyc);
          check("wb_ex", wb_ex, ms.is_ex);
          check("ertn_flush", ertn_flush, !ms.is_ex);
          check("wb_pc", wb_pc, ms.pc);
          check("wb_vaddr", wb_vaddr, ms.vaddr);
          if (ms.chk_code) begin
            check("wb_ecode", wb_ecode, ms.ecode);
            check("wb_esubcode", wb_esubcode, ms.sub);
          end
        end
      end
      if (redirect_valid && !prev_rv) first_offer = cyc;
      if (redirect_valid && prev_rv) check("redirect_pc_stable", redirect_pc, prev_rpc);
      if (redirect_valid && redirect_ready) begin
        if (rq.size() == 0) begin
          check("unexpected_redirect", redirect_valid, 0);
        end else begin
          mr = rq.pop_front();
          check("redirect_first_offer", first_offer, mr.cyc);
          check("redirect_pc", redirect_pc, mr.pc);
          check("redirect_flush", flush_all, 1);
        end
        inc_pending = 1'b1;
      end
      prev_rv  = redirect_valid;
      prev_rpc = redirect_pc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    resetn = 1'b0;
    clear_ws();
    ws_pc = 32'h0;
    ws_valid = 1'b1;
    z_valid = 1'b0; z_ex = 1'b0; z_ertn = 1'b0;
    redirect_ready = 1'b1;
    ex_entry = ENTRY;
    era_value = ERA;
    #2;
    check("rst_ws_ready", ws_ready, 0);
    check("rst_ws_commit", ws_commit, 0);
    check("rst_flush", flush_all, 0);
    check("rst_redirect_pc", redirect_pc, 0);
    #20;
    resetn = 1'b1;
    ws_valid = 1'b0;
    mon_en = 1'b1;
    tick();
    check("idle_ready", ws_ready, 1);
    check("idle_trap_count", trap_count, 0);

    // Normal retirement
    for (int i = 0; i < 10; i++) begin
      ws_valid = 1'b1;
      ws_pc = 32'h1c000000 + 32'(i * 4);
      #1;
      check("normal_commit", ws_commit, 1);
      check("normal_flush", flush_all, 0);
      tick();
    end
    clear_ws();

    // Exception trap with per-cycle strobe/flush profile
    k = cyc;
    trap(1, 0, 0, 6'h0b, 9'h000, 32'h1c000100, 32'h0000abcd, 1, 6'h0b, 9'h000, ENTRY);
    for (int i = 1; i <= 5; i++) begin
      check("ex_flush_profile", flush_all, (i <= 4) ? 1 : 0);
      check("ex_strobe_profile", wb_ex, (i == 1) ? 1 : 0);
      check("ex_redirect_profile", redirect_valid, (i == 4) ? 1 : 0);
      check("ex_cycle", cyc, k + i);
      tick();
    end
    check("ex_back_idle", ws_ready, 1);
    check("ecode_hold", wb_ecode, 6'h0b);
    check("pc_hold", wb_pc, 32'h1c000100);

    // ERTN
    trap(0, 1, 0, 6'h00, 9'h000, 32'h1c000300, 32'h0, 0, 6'h00, 9'h000, ERA);
    wait_idle("ertn_idle");

    // Priority: exception over interrupt and ERTN
    trap(1, 1, 1, 6'h09, 9'h005, 32'h1c000400, 32'h00000044, 1, 6'h09, 9'h005, ENTRY);
    wait_idle("prio_ex_idle");

    // Priority: interrupt over ERTN, pipeline code ignored
    trap(0, 1, 1, 6'h3f, 9'h1ff, 32'h1c000410, 32'h0, 1, 6'h00, 9'h000, ENTRY);
    wait_idle("prio_int_idle");

    // Interrupt without a valid WB instruction is not taken
    has_int = 1'b1;
    tick();
    tick();
    check("int_no_valid_idle", ws_ready, 1);
    clear_ws();

    // Redirect backpressure with noise on WB inputs
    redirect_ready = 1'b0;
    trap(1, 0, 0, 6'h08, 9'h000, 32'h1c000500, 32'h0, 1, 6'h08, 9'h000, ENTRY);
    for (int i = 2; i <= 9; i++) begin
      ws_valid = i[0];
      ws_ex = (i == 3 || i == 6);
      has_int = (i == 5);
      tick();
    end
    check("bp_still_offering", redirect_valid, 1);
    check("bp_count_held", trap_count, 4);
    clear_ws();
    redirect_ready = 1'b1;
    wait_idle("bp_idle");
    check("bp_trap_count", trap_count, 5);

    // Zero drain: redirect two cycles after the event cycle
    z_valid = 1'b1; z_ex = 1'b1;
    tick();
    z_valid = 1'b0; z_ex = 1'b0;
    check("z_strobe", z_wb_ex, 1);
    check("z_not_yet", z_redirect_valid, 0);
    tick();
    check("z_redirect", z_redirect_valid, 1);
    check("z_redirect_pc", z_redirect_pc, ENTRY);
    tick();
    check("z_idle", z_ws_ready, 1);
    check("z_trap_count", z_trap_count, 1);

    // Reset in DRAIN
    trap(1, 0, 0, 6'h0c, 9'h000, 32'h1c000600, 32'h0, 1, 6'h0c, 9'h000, ENTRY);
    tick();
    check("pre_rst_flush", flush_all, 1);
    resetn = 1'b0;
    #1;
    check("arst_flush", flush_all, 0);
    check("arst_strobes", {wb_ex, ertn_flush, redirect_valid}, 0);
    check("arst_ready", ws_ready, 0);
    check("arst_trap_count", trap_count, 0);
    check("arst_wb_pc", wb_pc, 0);
    check("arst_ecode", wb_ecode, 0);
    check("arst_redirect_pc", redirect_pc, 0);
    rq.delete();
    sq.delete();
    tick();
    #2;
    resetn = 1'b1;
    tick();
    check("post_rst_ready", ws_ready, 1);
    check("post_rst_flush", flush_all, 0);
    tick();
    check("post_rst_count", trap_count, 0);

    check("strobe_queue_empty", sq.size(), 0);
    check("redirect_queue_empty", rq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
